// File: rtl/contador_seq_ctrl.sv
// contador_seq_ctrl
//
// Command-driven sequencer for the 8-bit up-counter datapath. The block sits between the tile
// pin wrapper and the counter instance and owns the counter's enable and synchronous clear.
// Start/stop commands arrive on a valid/ready port. The sequencer then runs the counter with a
// prescaled tick in one of three modes:
//   - free-run:  count on every tick and let the counter wrap by itself;
//   - one-shot:  count up to a latched limit, pulse done and return to idle;
//   - periodic:  count up to the limit, pulse done, clear the counter and keep going.
//
// Optional feature macro: CNT_SEQ_PAUSE_EN
//   When it is defined, the block has a pause input. Holding pause high in RUN freezes the
//   prescaler, forces cnt_en low and suppresses terminal detection. In free-run mode a counter
//   carry-out (cnt_cout while cnt_en is high) is also counted as a period.
//   When it is undefined, the pause port and its logic are absent, and free-run never touches
//   periods.
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   cmd_valid  in   1        command strobe
//   cmd_ready  out  1        command taken on a clk edge where cmd_valid & cmd_ready
//   cmd_op     in   2        00 STOP, 01 START_FREE, 10 START_ONESHOT, 11 START_PERIODIC
//   cmd_limit  in   CNT_W    terminal counter value (ignored for START_FREE)
//   cmd_presc  in   PRESC_W  prescale divisor minus one
//   cnt_val    in   CNT_W    current counter value
//   cnt_cout   in   1        counter carry-out (wrap from all-ones)
//   cnt_en     out  1        counter enable, combinational
//   cnt_clr    out  1        counter synchronous clear, registered single-cycle pulse
//   busy       out  1        high while in ARM or RUN
//   done       out  1        registered single-cycle pulse per terminal event
//   periods    out  8        terminal events since the last START, wraps 255 -> 0
//   pause      in   1        freeze request (only with CNT_SEQ_PAUSE_EN)

module contador_seq_ctrl #(
  parameter int unsigned PRESC_W = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [CNT_W-1:0]   cmd_limit,
  input  logic [PRESC_W-1:0] cmd_presc,
  input  logic [CNT_W-1:0]   cnt_val,
  input  logic               cnt_cout,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic               busy,
  output logic               done,
  output logic [7:0]         periods
`ifdef CNT_SEQ_PAUSE_EN
  ,
  input  logic               pause
`endif
);

  // FSM encoding
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  // Command / mode encoding (the latched mode reuses the START opcode)
  localparam logic [1:0] OpStop     = 2'b00;
  localparam logic [1:0] OpFree     = 2'b01;
  localparam logic [1:0] OpOneshot  = 2'b10;
  localparam logic [1:0] OpPeriodic = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [PRESC_W-1:0] pc_q, pc_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [1:0]         mode_q, mode_d;
  logic [7:0]         periods_q, periods_d;
  logic               done_q, done_d;
  logic               clr_q, clr_d;

  logic run_paused;
  logic in_run;
  logic tick;
  logic terminal;
  logic period_evt;
  logic cmd_fire;
  logic is_start;

`ifdef CNT_SEQ_PAUSE_EN
  assign run_paused = pause;
`else
  assign run_paused = 1'b0;
  // Without the pause feature the carry-out has no consumer.
  logic unused_cout;
  assign unused_cout = cnt_cout;
`endif

  assign in_run   = (state_q == StRun);
  assign cmd_fire = cmd_valid & cmd_ready;
  assign is_start = (cmd_op != OpStop);

  assign tick = in_run & ~run_paused & (pc_q == presc_q);

  // While the periodic clear is in flight, cnt_val still shows the old terminal value.
  // Terminal detection and counting are masked for that one cycle. Otherwise the stale
  // value would re-trigger a terminal event, and any enable would be swallowed by the clear.
  assign terminal = tick & ~clr_q & (mode_q != OpFree) & (cnt_val == limit_q);
  assign cnt_en   = tick & ~clr_q & ~terminal;

`ifdef CNT_SEQ_PAUSE_EN
  assign period_evt = terminal | ((mode_q == OpFree) & cnt_en & cnt_cout);
`else
  assign period_evt = terminal;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    presc_d   = presc_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    periods_d = periods_q + {7'd0, period_evt};
    done_d    = terminal;
    clr_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        pc_d = '0;
        if (cmd_fire && is_start) begin
          mode_d    = cmd_op;
          limit_d   = cmd_limit;
          presc_d   = cmd_presc;
          periods_d = 8'd0;
          clr_d     = 1'b1;
          state_d   = StArm;
        end
      end

      StArm: begin
        pc_d    = '0;
        state_d = StRun;
      end

      StRun: begin
        if (!run_paused) begin
          pc_d = tick ? '0 : pc_q + 1'b1;
        end
        if (terminal && (mode_q == OpPeriodic)) begin
          clr_d = 1'b1;
        end
        if (terminal && (mode_q == OpOneshot)) begin
          state_d = StIdle;
        end
        if (cmd_fire) begin
          if (is_start) begin
            // Restart. An event in this same cycle still counts toward the new run.
            mode_d    = cmd_op;
            limit_d   = cmd_limit;
            presc_d   = cmd_presc;
            periods_d = {7'd0, period_evt};
            clr_d     = 1'b1;
            state_d   = StArm;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      presc_q   <= '0;
      limit_q   <= '0;
      mode_q    <= 2'b00;
      periods_q <= 8'd0;
      done_q    <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      presc_q   <= presc_d;
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      periods_q <= periods_d;
      done_q    <= done_d;
      clr_q     <= clr_d;
    end
  end

  // Ready is gated by rst_n so that it reads low while reset is asserted.
  assign cmd_ready = rst_n & (state_q != StArm);
  assign busy      = (state_q == StArm) | (state_q == StRun);
  assign done      = done_q;
  assign cnt_clr   = clr_q;
  assign periods   = periods_q;

endmodule
